dport_ext_axi: RTL and testbench
================================

Name: dport_ext_axi

Overview:
Downstream stage on the external side of the data-port TCM/ext address mux. It consumes mem_* requests routed to external memory and buffers them in a small in-order request FIFO. Each request is executed as a single-beat AXI4-Lite read or write, and an ack carrying the request tag is returned. Cache-maintenance requests (flush, invalidate, writeback) produce no bus traffic; they are acked in order.

Parameters:
REQ_DEPTH, 2, request FIFO entries (power of 2, >=2)
REQ_DEPTH_W, 1, log2(REQ_DEPTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
mem_addr_i  in  32  request address
mem_data_wr_i  in  32  write data
mem_rd_i  in  1  read request
mem_wr_i  in  4  write byte enables
mem_cacheable_i  in  1  ignored (accepted for interface compatibility)
mem_req_tag_i  in  11  request tag
mem_invalidate_i / mem_writeback_i / mem_flush_i  in  1 each  maintenance requests
mem_data_rd_o  out  32  read data, valid with ack
mem_accept_o  out  1  request accepted this cycle
mem_ack_o  out  1  response pulse
mem_error_o  out  1  response error, valid with ack
mem_resp_tag_o  out  11  tag of acked request
axi_awvalid_o out 1; axi_awaddr_o out 32; axi_awready_i in 1
axi_wvalid_o out 1; axi_wdata_o out 32; axi_wstrb_o out 4; axi_wready_i in 1
axi_bvalid_i in 1; axi_bresp_i in 2; axi_bready_o out 1
axi_arvalid_o out 1; axi_araddr_o out 32; axi_arready_i in 1
axi_rvalid_i in 1; axi_rdata_i in 32; axi_rresp_i in 2; axi_rready_o out 1

Behaviour:
- Reset: rst_i is asynchronous, active-high; clk_i is the clock. Reset empties the FIFO, sets the FSM to IDLE and drives all outputs to 0. Any in-flight AXI transaction is abandoned; the interconnect is reset together with this block.
- Request definition: request = rd | (wr!=0) | flush | invalidate | writeback.
- Accept: mem_accept_o = !fifo_full. A push happens when request & accept. There is no bypass, so a full FIFO blocks a push even in a cycle where it pops.
- FIFO entry: addr, data, wr, rd, tag. Pointers wrap modulo REQ_DEPTH. The count is REQ_DEPTH_W+1 bits.
- Execution: one transaction at a time, strictly in order.
- FSM states: IDLE, AW_W, B, AR, R.
- IDLE, FIFO not empty, head decode:
  - wr!=0 -> AW_W. A write takes priority over rd in the same entry.
  - else rd -> AR.
  - else (maintenance only) -> pop and ack next cycle; stay IDLE.
- AW_W: awvalid and wvalid rise together. Each is held until its own ready, tracked by separate done flags. When both are done -> B.
  - awaddr = {addr[31:2],2'b00}; wdata = data; wstrb = wr.
- B: bready=1. On bvalid -> pop, ack next cycle, go to IDLE.
- AR: arvalid held until arready, then -> R. araddr is word-aligned.
- R: rready=1. On rvalid -> capture rdata, pop, ack next cycle, go to IDLE.
- Ack: mem_ack_o is registered and lasts 1 cycle. mem_resp_tag_o = head tag. mem_data_rd_o = captured rdata for reads, 32'h0 for writes and maintenance. Outputs hold their values between acks.
- Valid stability: AXI valids never drop before their handshake completes; addr, data and strb are stable while valid.
- Latency, zero-wait slave: read accepted at cycle 0 -> arvalid/arready at 1 -> rvalid at 2 -> ack at 3. Maintenance accepted at 0 -> ack at 2.
- Back-to-back: IDLE evaluates the next head in the same cycle the previous ack is high.

Optional Feature:
DPORT_EXT_AXI_ERROR_EN
- Defined: mem_error_o is registered with the ack. It is 1 if the captured bresp/rresp != 2'b00, and 0 for maintenance requests.
- Undefined: mem_error_o is tied 0 and bresp/rresp are ignored.

Test Plan:
- Read addr 0x8000_0006, tag 0x155; zero-wait slave returns rdata 0xDEADBEEF. Required: araddr 0x8000_0004, ack at cycle 3, data 0xDEADBEEF, tag 0x155.
- Write addr 0x8000_0010, data 0x12345678, wr 4'b0011; awready delayed 3 cycles, wready immediate. Required: wvalid drops after 1 cycle, awvalid held 4 cycles, ack 1 cycle after bvalid, data_rd 0.
- REQ_DEPTH=2; three reads issued back-to-back with arready held low. Required: accept 1,1,0, third held. After release, acks appear in order with tags 1,2,3.
- flush tag 7 queued behind a read tag 6. Required: no AXI traffic for the flush; ack tag 6 then tag 7 on consecutive acks.
- With DPORT_EXT_AXI_ERROR_EN, rresp=2'b10. Required: ack with error=1. Without the macro, same stimulus gives error=0.
- Assert rst_i while in AW_W with awvalid high. Required: all valids, accept and ack go 0 immediately; after release, accept=1 and FIFO is empty.

Source files
------------

// File: rtl/dport_ext_axi.sv
// Data-port external-memory stage: in-order request FIFO feeding single-beat AXI4-Lite reads/writes.
// Optional feature macro: DPORT_EXT_AXI_ERROR_EN (report bresp/rresp errors on mem_error_o).
module dport_ext_axi #(
  parameter int REQ_DEPTH   = 2,
  parameter int REQ_DEPTH_W = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_wr_i,
  input  logic        mem_rd_i,
  input  logic [3:0]  mem_wr_i,
  input  logic        mem_cacheable_i,
  input  logic [10:0] mem_req_tag_i,
  input  logic        mem_invalidate_i,
  input  logic        mem_writeback_i,
  input  logic        mem_flush_i,
  output logic [31:0] mem_data_rd_o,
  output logic        mem_accept_o,
  output logic        mem_ack_o,
  output logic        mem_error_o,
  output logic [10:0] mem_resp_tag_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  output logic        axi_rready_o
);

  typedef enum logic [2:0] {S_IDLE, S_AW_W, S_B, S_AR, S_R} state_t;

  state_t                 state_q;
  logic                   aw_done_q, w_done_q;
  logic                   ack_q;
  logic [10:0]            tag_q;
  logic [31:0]            rdata_q;

  logic [29:0]            fifo_addr_q [REQ_DEPTH];
  logic [31:0]            fifo_data_q [REQ_DEPTH];
  logic [3:0]             fifo_wr_q   [REQ_DEPTH];
  logic                   fifo_rd_q   [REQ_DEPTH];
  logic [10:0]            fifo_tag_q  [REQ_DEPTH];
  logic [REQ_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [REQ_DEPTH_W:0]   count_q;

  logic request, fifo_full, fifo_empty, push, pop;
  logic [29:0] head_addr;
  logic [31:0] head_data;
  logic [3:0]  head_wr;
  logic        head_rd;
  logic [10:0] head_tag;
  logic issue_wr, issue_rd, issue_mnt;
  logic aw_hs, w_hs, aw_fin, w_fin, b_fin, r_fin;

  logic unused_in;
  assign unused_in = ^{mem_cacheable_i, mem_addr_i[1:0]};

  assign request    = mem_rd_i | (|mem_wr_i) | mem_flush_i | mem_invalidate_i | mem_writeback_i;
  assign fifo_full  = (count_q == (REQ_DEPTH_W+1)'(REQ_DEPTH));
  assign fifo_empty = (count_q == '0);
  // No bypass: a full FIFO refuses a push even in a cycle that pops.
  assign push       = request & ~fifo_full;
  assign mem_accept_o = ~rst_i & ~fifo_full;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_wr   = fifo_wr_q[rd_ptr_q];
  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_tag  = fifo_tag_q[rd_ptr_q];

  // IDLE launches the head directly so valids rise the cycle after a push.
  assign issue_wr  = (state_q == S_IDLE) && !fifo_empty && (head_wr != 4'h0);
  assign issue_rd  = (state_q == S_IDLE) && !fifo_empty && (head_wr == 4'h0) && head_rd;
  assign issue_mnt = (state_q == S_IDLE) && !fifo_empty && (head_wr == 4'h0) && !head_rd;

  assign axi_awvalid_o = issue_wr | ((state_q == S_AW_W) & ~aw_done_q);
  assign axi_wvalid_o  = issue_wr | ((state_q == S_AW_W) & ~w_done_q);
  assign axi_arvalid_o = issue_rd | (state_q == S_AR);
  assign axi_bready_o  = (state_q == S_B);
  assign axi_rready_o  = (state_q == S_R);

  assign axi_awaddr_o = axi_awvalid_o ? {head_addr, 2'b00} : 32'h0;
  assign axi_wdata_o  = axi_wvalid_o  ? head_data : 32'h0;
  assign axi_wstrb_o  = axi_wvalid_o  ? head_wr   : 4'h0;
  assign axi_araddr_o = axi_arvalid_o ? {head_addr, 2'b00} : 32'h0;

  assign aw_hs  = axi_awvalid_o & axi_awready_i;
  assign w_hs   = axi_wvalid_o & axi_wready_i;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;
  assign b_fin  = (state_q == S_B) & axi_bvalid_i;
  assign r_fin  = (state_q == S_R) & axi_rvalid_i;
  assign pop    = issue_mnt | b_fin | r_fin;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr_i[31:2];
      fifo_data_q[wr_ptr_q] <= mem_data_wr_i;
      fifo_wr_q[wr_ptr_q]   <= mem_wr_i;
      fifo_rd_q[wr_ptr_q]   <= mem_rd_i;
      fifo_tag_q[wr_ptr_q]  <= mem_req_tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ack_q     <= 1'b0;
      tag_q     <= 11'h0;
      rdata_q   <= 32'h0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (issue_wr) begin
            if (aw_hs && w_hs) state_q <= S_B;
            else begin
              state_q   <= S_AW_W;
              aw_done_q <= aw_hs;
              w_done_q  <= w_hs;
            end
          end else if (issue_rd) begin
            state_q <= axi_arready_i ? S_R : S_AR;
          end else if (issue_mnt) begin
            ack_q   <= 1'b1;
            tag_q   <= head_tag;
            rdata_q <= 32'h0;
          end
        end
        S_AW_W: begin
          if (aw_fin && w_fin) begin
            state_q   <= S_B;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
          end
        end
        S_B: if (axi_bvalid_i) begin
          state_q <= S_IDLE;
          ack_q   <= 1'b1;
          tag_q   <= head_tag;
          rdata_q <= 32'h0;
        end
        S_AR: if (axi_arready_i) state_q <= S_R;
        S_R: if (axi_rvalid_i) begin
          state_q <= S_IDLE;
          ack_q   <= 1'b1;
          tag_q   <= head_tag;
          rdata_q <= axi_rdata_i;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_ack_o      = ack_q;
  assign mem_resp_tag_o = tag_q;
  assign mem_data_rd_o  = rdata_q;

`ifdef DPORT_EXT_AXI_ERROR_EN
  logic err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (issue_mnt) err_q <= 1'b0;
    else if (b_fin)     err_q <= |axi_bresp_i;
    else if (r_fin)     err_q <= |axi_rresp_i;
  end
  assign mem_error_o = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{axi_bresp_i, axi_rresp_i};
  assign mem_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_dport_ext_axi.sv
// Randomized scoreboard bench for dport_ext_axi with a behavioural AXI4-Lite slave.
module tb_dport_ext_axi;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] mem_addr_i, mem_data_wr_i;
  logic        mem_rd_i, mem_cacheable_i, mem_invalidate_i, mem_writeback_i, mem_flush_i;
  logic [3:0]  mem_wr_i;
  logic [10:0] mem_req_tag_i;
  logic [31:0] mem_data_rd_o;
  logic        mem_accept_o, mem_ack_o, mem_error_o;
  logic [10:0] mem_resp_tag_o;
  logic        axi_awvalid_o, axi_awready_i, axi_wvalid_o, axi_wready_i;
  logic [31:0] axi_awaddr_o, axi_wdata_o, axi_araddr_o, axi_rdata_i;
  logic [3:0]  axi_wstrb_o;
  logic        axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i, axi_rvalid_i, axi_rready_o;
  logic [1:0]  axi_bresp_i, axi_rresp_i;

  dport_ext_axi #(.REQ_DEPTH(2), .REQ_DEPTH_W(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_addr_i(mem_addr_i), .mem_data_wr_i(mem_data_wr_i), .mem_rd_i(mem_rd_i),
    .mem_wr_i(mem_wr_i), .mem_cacheable_i(mem_cacheable_i), .mem_req_tag_i(mem_req_tag_i),
    .mem_invalidate_i(mem_invalidate_i), .mem_writeback_i(mem_writeback_i), .mem_flush_i(mem_flush_i),
    .mem_data_rd_o(mem_data_rd_o), .mem_accept_o(mem_accept_o), .mem_ack_o(mem_ack_o),
    .mem_error_o(mem_error_o), .mem_resp_tag_o(mem_resp_tag_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awready_i(axi_awready_i),
    .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
    .axi_wready_i(axi_wready_i), .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i),
    .axi_bready_o(axi_bready_o), .axi_arvalid_o(axi_arvalid_o), .axi_araddr_o(axi_araddr_o),
    .axi_arready_i(axi_arready_i), .axi_rvalid_i(axi_rvalid_i), .axi_rdata_i(axi_rdata_i),
    .axi_rresp_i(axi_rresp_i), .axi_rready_o(axi_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [10:0] tag; logic [31:0] data; logic err; int acc_cyc; int lat; } exp_t;
  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } bus_t;
  exp_t sb_q[$];
  bus_t bus_q[$];

  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_hi = 0, w_hi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave memory contents and response codes, shared by slave and reference model.
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[7:4] == 4'hE) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic err_exp(input bit bus, input logic [31:0] a);
`ifdef DPORT_EXT_AXI_ERROR_EN
    return bus && (resp_of(a) != 2'b00);
`else
    return 1'b0 & bus & a[0];
`endif
  endfunction

  task automatic clear_req();
    mem_rd_i = 0; mem_wr_i = 0; mem_flush_i = 0; mem_invalidate_i = 0; mem_writeback_i = 0;
    mem_addr_i = 0; mem_data_wr_i = 0; mem_req_tag_i = 0; mem_cacheable_i = 0;
  endtask

  // Called at a negedge; returns at a negedge. On timeout the request stays driven.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] wr, input bit rd,
                       input bit fl, input bit inv, input bit wb, input logic [10:0] tag,
                       input int lat, input int max_wait, output bit ok);
    exp_t e; bus_t b; logic [31:0] al;
    mem_addr_i = a; mem_data_wr_i = d; mem_wr_i = wr; mem_rd_i = rd; mem_flush_i = fl;
    mem_invalidate_i = inv; mem_writeback_i = wb; mem_req_tag_i = tag;
    mem_cacheable_i = 1'($urandom_range(0, 1));
    al = {a[31:2], 2'b00};
    ok = 0;
    for (int i = 0; i <= max_wait; i++) begin
      #1;
      if (mem_accept_o) begin ok = 1; break; end
      @(negedge clk_i);
    end
    if (ok) begin
      b.is_wr = (wr != 0); b.addr = al; b.data = d; b.strb = wr;
      e.tag = tag; e.acc_cyc = cyc; e.lat = lat;
      e.data = (wr == 0 && rd) ? rdata_of(al) : 32'h0;
      e.err = err_exp(wr != 0 || rd, al);
      sb_q.push_back(e);
      if (wr != 0 || rd) bus_q.push_back(b);
      @(negedge clk_i);
      clear_req();
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 500; i++) begin
      if (sb_q.size() == 0) begin done = 1; break; end
      @(negedge clk_i); #2;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    @(negedge clk_i);
  endtask

  // Response monitor: pops the scoreboard on every ack.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (axi_awvalid_o) aw_hi <= aw_hi + 1;
      if (axi_wvalid_o)  w_hi  <= w_hi + 1;
      if (mem_ack_o) begin
        if (sb_q.size() == 0) chk("ack_unexpected", 32'(mem_resp_tag_o), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("ack_tag", 32'(mem_resp_tag_o), 32'(e.tag));
          chk("ack_data", mem_data_rd_o, e.data);
          chk("ack_error", 32'(mem_error_o), 32'(e.err));
          if (e.lat >= 0) chk("ack_latency", cyc - e.acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic bus_front(input bit is_wr, input string nm, input logic [31:0] act, input int fld);
    if (bus_q.size() == 0 || bus_q[0].is_wr != is_wr) chk({nm, "_unexpected"}, act, 32'hFFFF_FFFF);
    else if (fld == 0) chk(nm, act, bus_q[0].addr);
    else if (fld == 1) chk(nm, act, bus_q[0].data);
    else               chk(nm, act, 32'(bus_q[0].strb));
  endtask

  // Behavioural AXI4-Lite slave; drives at negedge, handshakes land on the next posedge.
  initial begin
    bit pa_aw, pa_w, pa_ar, pa_b, pa_r, aw_got, w_got, b_pend, r_pend, st_aw, st_w, st_ar;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [31:0] b_addr, r_addr, st_awaddr, st_wdata, st_araddr;
    axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0;
    axi_rvalid_i = 0; axi_rdata_i = 0; axi_rresp_i = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0; axi_bvalid_i = 0; axi_rvalid_i = 0;
        {pa_aw, pa_w, pa_ar, pa_b, pa_r, aw_got, w_got, b_pend, r_pend, st_aw, st_w, st_ar} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        continue;
      end
      if (st_aw) begin chk("awvalid_stable", 32'(axi_awvalid_o), 1); chk("awaddr_stable", axi_awaddr_o, st_awaddr); end
      if (st_w)  begin chk("wvalid_stable", 32'(axi_wvalid_o), 1); chk("wdata_stable", axi_wdata_o, st_wdata); end
      if (st_ar) begin chk("arvalid_stable", 32'(axi_arvalid_o), 1); chk("araddr_stable", axi_araddr_o, st_araddr); end
      if (pa_aw) aw_got = 1;
      if (pa_w)  w_got = 1;
      if (aw_got && w_got && !b_pend) begin
        b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
        b_addr = (bus_q.size() != 0) ? bus_q[0].addr : 32'h0;
      end
      if (pa_b) begin axi_bvalid_i = 0; b_pend = 0; if (bus_q.size() != 0) void'(bus_q.pop_front()); end
      if (pa_ar) begin
        r_pend = 1; r_cnt = 0;
        r_addr = (bus_q.size() != 0) ? bus_q[0].addr : 32'h0;
      end
      if (pa_r) begin axi_rvalid_i = 0; r_pend = 0; if (bus_q.size() != 0) void'(bus_q.pop_front()); end
      axi_awready_i = 0;
      if (axi_awvalid_o && !aw_got) begin
        if (aw_cnt >= aw_dly) begin axi_awready_i = 1; aw_cnt = 0; bus_front(1, "awaddr", axi_awaddr_o, 0); end
        else aw_cnt++;
      end
      axi_wready_i = 0;
      if (axi_wvalid_o && !w_got) begin
        if (w_cnt >= w_dly) begin
          axi_wready_i = 1; w_cnt = 0;
          bus_front(1, "wdata", axi_wdata_o, 1); bus_front(1, "wstrb", 32'(axi_wstrb_o), 2);
        end else w_cnt++;
      end
      axi_arready_i = 0;
      if (axi_arvalid_o) begin
        if (ar_cnt >= ar_dly) begin axi_arready_i = 1; ar_cnt = 0; bus_front(0, "araddr", axi_araddr_o, 0); end
        else ar_cnt++;
      end
      if (b_pend && !axi_bvalid_i) begin
        if (b_cnt >= b_dly) begin axi_bvalid_i = 1; axi_bresp_i = resp_of(b_addr); end
        else b_cnt++;
      end
      if (r_pend && !axi_rvalid_i) begin
        if (r_cnt >= r_dly) begin axi_rvalid_i = 1; axi_rdata_i = rdata_of(r_addr); axi_rresp_i = resp_of(r_addr); end
        else r_cnt++;
      end
      pa_aw = axi_awvalid_o & axi_awready_i;
      pa_w  = axi_wvalid_o & axi_wready_i;
      pa_ar = axi_arvalid_o & axi_arready_i;
      pa_b  = axi_bvalid_i & axi_bready_o;
      pa_r  = axi_rvalid_i & axi_rready_o;
      st_aw = axi_awvalid_o & ~axi_awready_i; st_awaddr = axi_awaddr_o;
      st_w  = axi_wvalid_o & ~axi_wready_i;   st_wdata  = axi_wdata_o;
      st_ar = axi_arvalid_o & ~axi_arready_i; st_araddr = axi_araddr_o;
    end
  end

  initial begin
    bit ok, seen;
    logic [3:0] wr;
    bit rd, fl, inv, wb;
    int k;
    rst_i = 1;
    clear_req();
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_accept", 32'(mem_accept_o), 0);
    chk("rst_ack", 32'(mem_ack_o), 0);
    chk("rst_awvalid", 32'(axi_awvalid_o), 0);
    chk("rst_arvalid", 32'(axi_arvalid_o), 0);
    #1 rst_i = 0;
    @(negedge clk_i); #1;
    chk("post_rst_accept", 32'(mem_accept_o), 1);
    chk("post_rst_tag", 32'(mem_resp_tag_o), 0);
    chk("post_rst_data", mem_data_rd_o, 0);
    @(negedge clk_i);

    // zero-wait read, ack three cycles after accept
    issue(32'h8000_0006, 0, 0, 1, 0, 0, 0, 11'h155, 3, 5, ok);
    drain();

    // write with awready delayed three cycles
    aw_dly = 3; aw_hi = 0; w_hi = 0;
    issue(32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 11'h0A1, 6, 5, ok);
    drain();
    chk("awvalid_cycles", aw_hi, 4);
    chk("wvalid_cycles", w_hi, 1);
    aw_dly = 0;

    // FIFO full with arready held low
    ar_dly = 1000;
    issue(32'h0000_1000, 0, 0, 1, 0, 0, 0, 11'd1, -1, 0, ok); chk("accept_1", 32'(ok), 1);
    issue(32'h0000_1004, 0, 0, 1, 0, 0, 0, 11'd2, -1, 0, ok); chk("accept_2", 32'(ok), 1);
    issue(32'h0000_1008, 0, 0, 1, 0, 0, 0, 11'd3, -1, 3, ok); chk("accept_3_blocked", 32'(ok), 0);
    chk("accept_low_full", 32'(mem_accept_o), 0);
    ar_dly = 0;
    issue(32'h0000_1008, 0, 0, 1, 0, 0, 0, 11'd3, -1, 50, ok); chk("accept_3_release", 32'(ok), 1);
    drain();

    // maintenance queued behind a read: consecutive acks
    issue(32'h0000_2000, 0, 0, 1, 0, 0, 0, 11'd6, 3, 5, ok);
    issue(32'h0000_2040, 0, 0, 0, 1, 0, 0, 11'd7, 3, 5, ok);
    drain();
    issue(32'h0000_3000, 0, 0, 0, 0, 1, 0, 11'h022, 2, 5, ok);
    drain();

    // error responses
    issue(32'h0000_00E0, 0, 0, 1, 0, 0, 0, 11'h03E, 3, 5, ok);
    issue(32'h0000_00E4, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 11'h03F, -1, 50, ok);
    drain();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      k = $urandom_range(0, 9);
      wr = 0; rd = 0; fl = 0; inv = 0; wb = 0;
      if (k < 4) rd = 1;
      else if (k < 8) begin wr = 4'($urandom_range(1, 15)); rd = 1'($urandom_range(0, 1)); end
      else case ($urandom_range(0, 2))
        0: fl = 1;
        1: inv = 1;
        default: wb = 1;
      endcase
      issue($urandom, $urandom, wr, rd, fl, inv, wb, 11'($urandom), -1, 200, ok);
      chk("rand_accept", 32'(ok), 1);
      if (!ok) begin @(negedge clk_i); clear_req(); end
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    drain();
    chk("bus_queue_empty", bus_q.size(), 0);
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;

    // reset while a write sits in AW_W
    aw_dly = 1000;
    issue(32'h0000_4000, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 11'h044, -1, 5, ok);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (axi_awvalid_o) begin seen = 1; break; end
      @(negedge clk_i);
    end
    chk("awvalid_before_rst", 32'(seen), 1);
    @(negedge clk_i); #2 rst_i = 1; #1;
    chk("arst_awvalid", 32'(axi_awvalid_o), 0);
    chk("arst_wvalid", 32'(axi_wvalid_o), 0);
    chk("arst_arvalid", 32'(axi_arvalid_o), 0);
    chk("arst_accept", 32'(mem_accept_o), 0);
    chk("arst_ack", 32'(mem_ack_o), 0);
    sb_q.delete(); bus_q.delete();
    aw_dly = 0;
    repeat (2) @(negedge clk_i);
    #2 rst_i = 0;
    @(negedge clk_i); #1;
    chk("arel_accept", 32'(mem_accept_o), 1);
    repeat (3) @(negedge clk_i); #1;
    chk("arel_awvalid", 32'(axi_awvalid_o), 0);
    chk("arel_arvalid", 32'(axi_arvalid_o), 0);
    chk("arel_ack", 32'(mem_ack_o), 0);
    @(negedge clk_i);
    issue(32'h8000_0004, 0, 0, 1, 0, 0, 0, 11'h155, 3, 5, ok);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
